// File: rtl/divider_w.sv
// Iterative restoring divider for a CPU DIV instruction: unsigned or signed (floored) mode,
// BPC quotient bits per cycle, result held until the next completed operation.
module divider_w #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             u,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             stall,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dz_q;

  logic [WIDTH-1:0] r_q, qs_q, ym_q, yv_q;
  logic             sx_q, sy_q;

  logic [WIDTH-1:0]   xm_c, ym_c;
  logic [2*WIDTH-1:0] step_c, fix_c;

  // BPC restoring steps: shift the next dividend bit into the partial remainder,
  // subtract the divisor magnitude when it fits and record the quotient bit.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] rr, qq;
    rr = r;
    qq = q;
    for (int i = 0; i < BPC; i++) begin
      t  = {rr, qq[WIDTH-1]};
      qq = {qq[WIDTH-2:0], 1'b0};
      if (t >= {1'b0, d}) begin
        t     = t - {1'b0, d};
        qq[0] = 1'b1;
      end
      rr = t[WIDTH-1:0];
    end
    return {rr, qq};
  endfunction

  // Turn magnitude results into a floored signed result; identity when both signs are 0.
  function automatic logic [2*WIDTH-1:0] floor_fix(input logic [WIDTH-1:0] qm,
                                                   input logic [WIDTH-1:0] rm,
                                                   input logic [WIDTH-1:0] yv,
                                                   input logic sx,
                                                   input logic sy);
    logic signed [WIDTH-1:0] qt, rt;
    qt = (sx ^ sy) ? -qm : qm;
    rt = sx ? -rm : rm;
    if ((rt != '0) && (sx != sy)) begin
      qt = qt - ONE;
      rt = rt + yv;
    end
    return {qt, rt};
  endfunction

  assign xm_c   = (u && x[WIDTH-1]) ? -x : x;
  assign ym_c   = (u && y[WIDTH-1]) ? -y : y;
  assign step_c = div_step(r_q, qs_q, ym_q);
  assign fix_c  = floor_fix(qs_q, r_q, yv_q, sx_q, sy_q);

  assign stall = run && (state_q != DONE);
  assign quot  = quot_q;
  assign rem   = rem_q;
  assign dz    = dz_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            if (y == '0) begin
              state_q <= DONE;
              quot_q  <= '1;
              rem_q   <= x;
              dz_q    <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= '0;
            end
          end
        end
        BUSY: begin
          if (!run)               state_q <= IDLE;
          else if (cnt_q == LAST) state_q <= FIX;
          else                    cnt_q   <= cnt_q + 1'b1;
        end
        FIX: begin
          if (!run) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
            quot_q  <= fix_c[2*WIDTH-1:WIDTH];
            rem_q   <= fix_c[WIDTH-1:0];
            dz_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand capture happens only on the IDLE->BUSY transition; BUSY just iterates.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && run && y != '0) begin
      r_q  <= '0;
      qs_q <= xm_c;
      ym_q <= ym_c;
      yv_q <= y;
      sx_q <= u & x[WIDTH-1];
      sy_q <= u & y[WIDTH-1];
    end else if (state_q == BUSY) begin
      r_q  <= step_c[2*WIDTH-1:WIDTH];
      qs_q <= step_c[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_divider_w.sv
// Bench for divider_w: a 32-bit/1-bit-per-cycle instance and a 16-bit/2-bit-per-cycle instance,
// compared against an arithmetic reference model.
module tb_divider_w;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, u, stall, dz;
  logic [31:0] x, y, quot, rem;
  logic        run16, u16, stall16, dz16;
  logic [15:0] x16, y16, quot16, rem16;

  int total = 0;
  int bad   = 0;

  divider_w #(.WIDTH(32), .BPC(1)) dut32 (
    .clk(clk), .rst(rst), .run(run), .u(u), .x(x), .y(y),
    .stall(stall), .quot(quot), .rem(rem), .dz(dz)
  );

  divider_w #(.WIDTH(16), .BPC(2)) dut16 (
    .clk(clk), .rst(rst), .run(run16), .u(u16), .x(x16), .y(y16),
    .stall(stall16), .quot(quot16), .rem(rem16), .dz(dz16)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, floored for signed mode, all-ones/x on divide by zero.
  function automatic void model(input int w, input logic uu,
                                input longint unsigned xx, input longint unsigned yy,
                                output longint unsigned q, output longint unsigned r,
                                output logic d);
    longint unsigned m;
    longint signed   xs, ys, qs, rs;
    m = (64'd1 << w) - 64'd1;
    if (yy == 0) begin
      q = m; r = xx; d = 1'b1;
      return;
    end
    d = 1'b0;
    if (!uu) begin
      q = xx / yy;
      r = xx % yy;
    end else begin
      xs = ((xx >> (w - 1)) != 0) ? $signed(xx) - $signed(m + 64'd1) : $signed(xx);
      ys = ((yy >> (w - 1)) != 0) ? $signed(yy) - $signed(m + 64'd1) : $signed(yy);
      qs = xs / ys;
      rs = xs - qs * ys;
      if (rs != 0 && ((rs < 0) != (ys < 0))) begin
        qs = qs - 1;
        rs = rs + ys;
      end
      q = $unsigned(qs) & m;
      r = $unsigned(rs) & m;
    end
  endfunction

  // Called just after a falling edge; counts stall cycles until the result cycle.
  task automatic run_op32(input logic uu, input logic [31:0] xx, input logic [31:0] yy,
                          input bit scramble, output int cyc,
                          output logic [31:0] q, output logic [31:0] r, output logic d);
    u = uu; x = xx; y = yy; run = 1'b1; cyc = 0;
    #1;
    while (stall === 1'b1 && cyc < 200) begin
      cyc++;
      if (scramble && cyc == 2) begin
        x = $urandom; y = $urandom; u = 1'($urandom);
      end
      @(negedge clk); #1;
    end
    q = quot; r = rem; d = dz;
  endtask

  task automatic run_op16(input logic uu, input logic [15:0] xx, input logic [15:0] yy,
                          input bit scramble, output int cyc,
                          output logic [15:0] q, output logic [15:0] r, output logic d);
    u16 = uu; x16 = xx; y16 = yy; run16 = 1'b1; cyc = 0;
    #1;
    while (stall16 === 1'b1 && cyc < 200) begin
      cyc++;
      if (scramble && cyc == 2) begin
        x16 = 16'($urandom); y16 = 16'($urandom); u16 = 1'($urandom);
      end
      @(negedge clk); #1;
    end
    q = quot16; r = rem16; d = dz16;
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; run16 = 1'b0; u = 1'b0; u16 = 1'b0;
    x = '0; y = '0; x16 = '0; y16 = '0;
    #2;
    total++;
    if (quot !== 32'd0 || rem !== 32'd0 || dz !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset32: got q=%h r=%h dz=%b st=%b, need zeros", quot, rem, dz, stall);
    end
    total++;
    if (quot16 !== 16'd0 || rem16 !== 16'd0 || dz16 !== 1'b0) begin
      bad++;
      $display("FAIL reset16: got q=%h r=%h dz=%b, need zeros", quot16, rem16, dz16);
    end
    run = 1'b1; #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL reset_stall: got %b need 1", stall);
    end
    run = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned_basic();
    int cyc; logic [31:0] q, r; logic d;
    run_op32(1'b0, 32'd100, 32'd7, 1'b0, cyc, q, r, d);
    total++;
    if (cyc !== 34 || q !== 32'd14 || r !== 32'd2 || d !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_100_7: got cyc=%0d q=%0d r=%0d dz=%b, need 34 14 2 0", cyc, q, r, d);
    end
    run = 1'b0; @(negedge clk);
    total++;
    if (stall !== 1'b0 || quot !== 32'd14 || rem !== 32'd2) begin
      bad++; $display("FAIL hold_after_done: got st=%b q=%0d r=%0d", stall, quot, rem);
    end
  endtask

  task automatic test_signed();
    logic [31:0] tx [3] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF8};
    logic [31:0] ty [3] = '{32'd2, 32'hFFFFFFFE, 32'd2};
    longint unsigned eq, er; logic ed;
    int cyc; logic [31:0] q, r; logic d;
    for (int i = 0; i < 3; i++) begin
      model(32, 1'b1, tx[i], ty[i], eq, er, ed);
      run_op32(1'b1, tx[i], ty[i], 1'b0, cyc, q, r, d);
      total++;
      if (cyc !== 34 || q !== eq[31:0] || r !== er[31:0] || d !== 1'b0) begin
        bad++;
        $display("FAIL signed_%0d: got cyc=%0d q=%h r=%h dz=%b, need 34 %h %h 0",
                 i, cyc, q, r, d, eq[31:0], er[31:0]);
      end
      if (i == 0) begin
        total++;
        if (q !== 32'hFFFFFFFC || r !== 32'd1) begin
          bad++; $display("FAIL signed_m7_2: got q=%h r=%h need fffffffc 1", q, r);
        end
      end
      run = 1'b0; @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int cyc; logic [31:0] q, r; logic d;
    run_op32(1'b0, 32'h1234, 32'd0, 1'b0, cyc, q, r, d);
    total++;
    if (cyc !== 1 || q !== 32'hFFFFFFFF || r !== 32'h1234 || d !== 1'b1) begin
      bad++;
      $display("FAIL div_zero: got cyc=%0d q=%h r=%h dz=%b, need 1 ffffffff 1234 1", cyc, q, r, d);
    end
    run = 1'b0; @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] q, r; logic d;
    run_op32(1'b0, 32'd100, 32'd7, 1'b0, cyc, q, r, d);
    total++;
    if (cyc !== 34 || q !== 32'd14 || r !== 32'd2) begin
      bad++; $display("FAIL b2b_first: got cyc=%0d q=%0d r=%0d", cyc, q, r);
    end
    u = 1'b1; x = 32'h80000000; y = 32'hFFFFFFFF;
    @(negedge clk); #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL b2b_gap: stall got %b need 1 after one low cycle", stall);
    end
    run_op32(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, q, r, d);
    total++;
    if (cyc !== 34 || q !== 32'h80000000 || r !== 32'd0 || d !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: got cyc=%0d q=%h r=%h dz=%b, need 34 80000000 0 0", cyc, q, r, d);
    end
    run = 1'b0; @(negedge clk);
  endtask

  task automatic test_abort();
    int cyc; logic [31:0] q, r, pq, pr; logic d;
    pq = quot; pr = rem;
    u = 1'b0; x = 32'd1000; y = 32'd3; run = 1'b1;
    repeat (10) @(negedge clk);
    run = 1'b0;
    @(negedge clk); #1;
    total++;
    if (quot !== pq || rem !== pr || dz !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL abort_hold: got q=%h r=%h dz=%b, need %h %h 0", quot, rem, dz, pq, pr);
    end
    @(negedge clk);
    run_op32(1'b0, 32'd100, 32'd7, 1'b0, cyc, q, r, d);
    total++;
    if (cyc !== 34 || q !== 32'd14 || r !== 32'd2) begin
      bad++; $display("FAIL abort_restart: got cyc=%0d q=%0d r=%0d, need 34 14 2", cyc, q, r);
    end
    run = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int cyc; logic [31:0] q, r; logic d;
    u = 1'b0; x = 32'd99; y = 32'd5; run = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (quot !== 32'd0 || rem !== 32'd0 || dz !== 1'b0 || stall !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy: got q=%h r=%h dz=%b st=%b, need 0 0 0 1", quot, rem, dz, stall);
    end
    x = 32'd100; y = 32'd7;
    @(negedge clk); rst = 1'b1;
    run_op32(1'b0, 32'd100, 32'd7, 1'b0, cyc, q, r, d);
    total++;
    if (cyc !== 34 || q !== 32'd14 || r !== 32'd2) begin
      bad++; $display("FAIL reset_restart: got cyc=%0d q=%0d r=%0d, need 34 14 2", cyc, q, r);
    end
    run = 1'b0; @(negedge clk);
  endtask

  task automatic test_random32();
    int cyc, sel, ecyc; logic uu; logic [31:0] xx, yy, q, r; logic d;
    longint unsigned eq, er; logic ed;
    for (int i = 0; i < 30; i++) begin
      uu = 1'($urandom); xx = $urandom; yy = $urandom; sel = $urandom_range(0, 5);
      case (sel)
        0: yy = 32'd0;
        1: yy = $urandom_range(1, 15);
        2: yy = -32'($urandom_range(1, 15));
        3: begin xx = 32'h80000000; yy = 32'hFFFFFFFF; end
        default: ;
      endcase
      model(32, uu, xx, yy, eq, er, ed);
      ecyc = (yy == 0) ? 1 : 34;
      run_op32(uu, xx, yy, 1'b1, cyc, q, r, d);
      total++;
      if (cyc !== ecyc || q !== eq[31:0] || r !== er[31:0] || d !== ed) begin
        bad++;
        $display("FAIL rand32_%0d u=%b x=%h y=%h: got cyc=%0d q=%h r=%h dz=%b, need %0d %h %h %b",
                 i, uu, xx, yy, cyc, q, r, d, ecyc, eq[31:0], er[31:0], ed);
      end
      run = 1'b0; @(negedge clk);
    end
  endtask

  task automatic test_width16_bpc2();
    int cyc, ecyc; logic uu; logic [15:0] xx, yy, q, r; logic d;
    longint unsigned eq, er; logic ed;
    run_op16(1'b0, 16'hFFFF, 16'h0003, 1'b0, cyc, q, r, d);
    total++;
    if (cyc !== 10 || q !== 16'h5555 || r !== 16'h0000 || d !== 1'b0) begin
      bad++;
      $display("FAIL w16_ffff_3: got cyc=%0d q=%h r=%h dz=%b, need 10 5555 0 0", cyc, q, r, d);
    end
    run16 = 1'b0; @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      uu = 1'($urandom); xx = 16'($urandom);
      yy = (i % 4 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      model(16, uu, xx, yy, eq, er, ed);
      ecyc = (yy == 0) ? 1 : 10;
      run_op16(uu, xx, yy, 1'b1, cyc, q, r, d);
      total++;
      if (cyc !== ecyc || q !== eq[15:0] || r !== er[15:0] || d !== ed) begin
        bad++;
        $display("FAIL rand16_%0d u=%b x=%h y=%h: got cyc=%0d q=%h r=%h dz=%b, need %0d %h %h %b",
                 i, uu, xx, yy, cyc, q, r, d, ecyc, eq[15:0], er[15:0], ed);
      end
      run16 = 1'b0; @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid_busy();
    test_random32();
    test_width16_bpc2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
